// File: rtl/alu_md_ctrl.sv
// rtl/alu_md_ctrl.sv - EX-stage ALU decoder with iterative mult/div sequencer and HI/LO registers
module alu_md_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic             illegal,
    output logic             md_busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [WIDTH-1:0] acc_d, b_d, hi_d, lo_d;
    logic             is_div_q, neg_res_q, neg_rem_q, div0_q;

    logic             is_rtype, is_md, is_muldiv, is_mthi, is_mtlo, signed_op;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        alucontrol = 4'b1111;
        illegal    = 1'b0;
        case (aluop)
            2'b00: alucontrol = 4'b0010;
            2'b01: alucontrol = 4'b0110;
            2'b11: alucontrol = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 4'b0010;
                    6'b100010: alucontrol = 4'b0110;
                    6'b100100: alucontrol = 4'b0000;
                    6'b100101: alucontrol = 4'b0001;
                    6'b100110: alucontrol = 4'b0011;
                    6'b100111: alucontrol = 4'b0100;
                    6'b101010: alucontrol = 4'b0111;
                    6'b101011: alucontrol = 4'b1000;
                    6'b000000: alucontrol = 4'b1001;
                    6'b000010: alucontrol = 4'b1010;
                    6'b000011: alucontrol = 4'b1011;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011: alucontrol = 4'b0010;
                    default: begin
                        alucontrol = 4'b1111;
                        illegal    = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign is_rtype  = (aluop == 2'b10);
    assign is_muldiv = is_rtype && (funct[5:2] == 4'b0110);
    assign is_md     = is_muldiv || (is_rtype && (funct[5:2] == 4'b0100));
    assign is_mthi   = is_rtype && (funct == 6'b010001);
    assign is_mtlo   = is_rtype && (funct == 6'b010011);
    assign signed_op = !funct[0];
    assign sign_a    = signed_op && srca[WIDTH-1];
    assign sign_b    = signed_op && srcb[WIDTH-1];
    assign mag_a     = sign_a ? -srca : srca;
    assign mag_b     = sign_b ? -srcb : srcb;

    // a_q holds multiplicand/divisor; b_q holds multiplier/dividend and collects the low product or quotient
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, b_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, a_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
                acc_d = div_diff[WIDTH-1:0];
                b_d   = {b_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                b_d   = {b_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            b_d   = {mul_sum[0], b_q[WIDTH-1:1]};
        end

        prod = {acc_d, b_d};
        if (neg_res_q) prod = -prod;
        quo = neg_res_q ? -b_d : b_d;
        rem = neg_rem_q ? -acc_d : acc_d;
        if (div0_q) quo = '1;
        if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
        end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && is_muldiv && !flush) begin
                        state_q   <= BUSY;
                        cnt_q     <= CNT_W'(WIDTH);
                        acc_q     <= '0;
                        a_q       <= mag_b;
                        b_q       <= mag_a;
                        is_div_q  <= funct[1];
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        div0_q    <= (srcb == '0);
                    end else if (en && is_mthi) begin
                        hi_q <= srca;
                    end else if (en && is_mtlo) begin
                        lo_q <= srca;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        b_q   <= b_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_busy = (state_q == BUSY);
    assign stall   = md_busy && en && is_md;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule
